// File: rtl/fifo_write_arbiter_if.sv
// Write-side bus between the producers and the FIFO write arbiter.
interface fifo_write_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] data;
  logic [NREQ-1:0]    ack;
  logic               fifo_full;
  logic               fifo_wr;
  logic [DW-1:0]      fifo_wdata;
  logic [2:0]         owner;
  logic               busy;

  // Producer / FIFO side: presents requests and the full flag.
  modport master (
    output req, data, fifo_full,
    input  ack, fifo_wr, fifo_wdata, owner, busy
  );

  // Arbiter side.
  modport slave (
    input  req, data, fifo_full,
    output ack, fifo_wr, fifo_wdata, owner, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers,
// with a per-grant burst limit and combinational full back-pressure.
module fifo_write_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned BURST = 4
) (
  input logic                 clk,
  input logic                 reset,
  fifo_write_arbiter_if.slave bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_owner, w_owner_nxt;
  logic [2:0]      r_ptr, w_ptr_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic [2:0]      w_owner_inc;
  logic            w_own_req;
  logic [DW-1:0]   w_own_data;
  logic            w_fire;
  logic            w_release;
  logic [NREQ-1:0] w_ack;

  // Lowest requesting index at or after p, wrapping modulo NREQ.
  function automatic logic [2:0] pick(input logic [NREQ-1:0] v, input logic [2:0] p);
    logic [2:0]  res;
    int unsigned idx;
    res = '0;
    // Scan offsets from largest to smallest so the nearest hit wins.
    for (int unsigned k = NREQ; k > 0; k--) begin
      idx = (32'(p) + k - 1) % NREQ;
      if (v[idx]) res = idx[2:0];
    end
    return res;
  endfunction

  assign w_owner_inc = (r_owner == 3'(NREQ - 1)) ? '0 : r_owner + 3'd1;

  // Select the current owner's request and byte.
  always_comb begin
    w_own_req  = 1'b0;
    w_own_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_owner == 3'(i)) begin
        w_own_req  = bus.req[i];
        w_own_data = bus.data[i*DW +: DW];
      end
    end
  end

  // Acceptance and FIFO write drive; full blocks acceptance in the same cycle.
  always_comb begin
    w_fire = (r_state == S_GRANT) && w_own_req && !bus.fifo_full;
    w_ack  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_fire && (r_owner == 3'(i))) w_ack[i] = 1'b1;
    end
  end

  assign bus.ack        = w_ack;
  assign bus.fifo_wr    = w_fire;
  assign bus.fifo_wdata = w_fire ? w_own_data : '0;
  assign bus.owner      = r_owner;
  assign bus.busy       = (r_state == S_GRANT);

  assign w_release = !w_own_req || (w_fire && (r_cnt == 4'(BURST - 1)));

  // Next-state logic: arbitration, release and burst counting.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (|bus.req) begin
          w_state_nxt = S_GRANT;
          w_owner_nxt = pick(bus.req, r_ptr);
          w_cnt_nxt   = '0;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_ptr_nxt = w_owner_inc;
          // On a dropped request the owner's bit is already clear, so req
          // itself is the candidate set in both release cases.
          if (|bus.req) begin
            w_owner_nxt = pick(bus.req, w_owner_inc);
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_fire) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule
